response_capture_ctrl: RTL and testbench
========================================

RESPONSE_CAPTURE_CTRL -- requirements
Module: response_capture_ctrl

Interface
REQ-001 Parameter DATA_W, 11, width of the DUT response bus.
REQ-002 Parameter FIFO_DEPTH, 16, number of captured responses held (power of two).
REQ-003 Port clk  input  1  system clock; all logic is rising-edge.
REQ-004 Port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 Port address  input  3  Avalon-MM slave word address.
REQ-006 Port read / write  input  1 each  Avalon-MM strobes; zero wait states.
REQ-007 Port writedata  input  32  write data.
REQ-008 Port readdata  output  32  registered read data; unused bits zero.
REQ-009 Port in_port  input  DATA_W  asynchronous DUT response bus.
REQ-010 Port irq  output  1  capture-complete interrupt, level.

Function
REQ-011 in_port shall pass a two-flop synchronizer; samples shall use the second stage.
REQ-012 Register map: 0 CTRL, 1 COUNT[15:0], 2 DIVIDER[15:0], 3 EXPECT[DATA_W-1:0], 4 MASK[DATA_W-1:0], 5 STATUS, 6 FIFO data, 7 MISMATCH[15:0].
REQ-013 CTRL write: bit0 start (self-clearing), bit1 abort (self-clearing), bit2 irq_en (stored); CTRL read: bit2 irq_en, bit0 busy.
REQ-014 STATUS read: bit0 busy, bit1 done, bit2 fifo_empty, bit3 fifo_full, bit4 overflow, bits[15:8] FIFO level; writing 1 to bit1 or bit4 shall clear that bit.
REQ-015 readdata shall update one cycle after read is asserted, for every address.
REQ-016 A read of address 6 shall return the FIFO head and pop it; on empty it shall return 0 and not change state.
REQ-017 FSM states: IDLE, WAIT, SAMPLE, DONE.
REQ-018 IDLE + start: load remaining=COUNT, interval counter=DIVIDER, clear done, overflow and MISMATCH, flush FIFO; go WAIT, or DONE if COUNT=0.
REQ-019 WAIT: decrement interval counter; at 0 go SAMPLE (interval between samples = DIVIDER+1 clocks).
REQ-020 SAMPLE (one cycle): push synchronized sample, decrement remaining; go DONE if remaining becomes 0, else reload counter, go WAIT.
REQ-021 DONE (one cycle): set done, go IDLE.
REQ-022 busy shall be 1 in WAIT and SAMPLE only.
REQ-023 Start while busy shall be ignored; abort shall return to IDLE within one cycle without setting done, keeping FIFO contents.
REQ-024 Start and abort in the same write: abort wins.
REQ-025 Push when full: sample dropped, overflow set (sticky), remaining still decremented.
REQ-026 Push and pop in the same cycle: both take effect, including when full or empty (empty: pop returns 0, push stored).
REQ-027 COUNT/DIVIDER/EXPECT/MASK writes during busy shall take effect only at the next start.
REQ-028 irq = done AND irq_en.

Reset
REQ-029 On reset_n low: FSM IDLE, readdata 0, irq 0, all registers 0, FIFO empty, synchronizer 0.
REQ-030 Reset mid-capture shall abandon the capture with no done or irq.

Configuration
REQ-031 With RESP_COMPARE_EN defined, each SAMPLE with ((sample XOR EXPECT) AND MASK) != 0 shall increment MISMATCH, saturating at 0xFFFF.
REQ-032 Without RESP_COMPARE_EN, EXPECT, MASK and MISMATCH shall not be implemented and addresses 3, 4, 7 shall read 0.

Verification
REQ-033 COUNT=4, DIVIDER=2, in_port ramp 0x001..0x004 held per interval, start -> 4 FIFO entries in order, done at ~12 clocks, STATUS level=4.
REQ-034 COUNT=20, DIVIDER=0, no reads -> 16 entries, fifo_full=1, overflow=1, done=1.
REQ-035 COUNT=0, irq_en=1, start -> done and irq within 2 clocks, FIFO empty; write STATUS 0x2 -> irq=0.
REQ-036 COUNT=100, start, abort after 10 clocks -> busy=0, done=0, irq=0; partial entries still readable.
REQ-037 RESP_COMPARE_EN, EXPECT=0x7FF, MASK=0x00F, samples 0x7FF,0x7F0,0x0FF -> MISMATCH=1; without macro address 7 reads 0.
REQ-038 Pulse reset_n low mid-capture -> all outputs 0, FIFO empty, next start runs normally.

Source files
------------

// File: rtl/response_capture_ctrl.sv
// Avalon-MM controlled capture of a synchronized DUT response bus into a FIFO.
// Define RESP_COMPARE_EN to add EXPECT/MASK registers and a saturating MISMATCH counter.
module response_capture_ctrl #(
  parameter int DATA_W     = 11,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [DATA_W-1:0] in_port,
  output logic              irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SAMPLE, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] sync1_q, sync2_q;
  logic [15:0]       count_q, count_d, divider_q, divider_d, reload_q, reload_d;
  logic [15:0]       remaining_q, remaining_d, interval_q, interval_d;
  logic              irq_en_q, irq_en_d, done_q, done_d, overflow_q, overflow_d;
  logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [31:0]       readdata_q, readdata_d;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_head;
  logic [AW:0]       level;
  logic              push_req, push_en, pop_en, busy, fifo_empty, fifo_full;
  logic              wr_start, wr_abort;
`ifdef RESP_COMPARE_EN
  logic [DATA_W-1:0] expect_q, expect_d, mask_q, mask_d;
  logic [DATA_W-1:0] expect_act_q, expect_act_d, mask_act_q, mask_act_d;
  logic [15:0]       mismatch_q, mismatch_d;
`endif
  logic              unused_wdata;

  assign unused_wdata = ^writedata[31:16];
  assign level        = wr_ptr_q - rd_ptr_q;
  assign fifo_empty   = (level == '0);
  assign fifo_full    = (level == DEPTH_L);
  assign fifo_head    = fifo_mem[rd_ptr_q[AW-1:0]];
  assign busy         = (state_q == S_WAIT) || (state_q == S_SAMPLE);
  // abort dominates start when both bits arrive in one write
  assign wr_abort     = write && (address == 3'd0) && writedata[1];
  assign wr_start     = write && (address == 3'd0) && writedata[0] && !writedata[1];
  assign irq          = done_q & irq_en_q;
  assign readdata     = readdata_q;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    divider_d   = divider_q;
    reload_d    = reload_q;
    remaining_d = remaining_q;
    interval_d  = interval_q;
    irq_en_d    = irq_en_q;
    done_d      = done_q;
    overflow_d  = overflow_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    readdata_d  = readdata_q;
    push_req    = 1'b0;
`ifdef RESP_COMPARE_EN
    expect_d     = expect_q;
    mask_d       = mask_q;
    expect_act_d = expect_act_q;
    mask_act_d   = mask_act_q;
    mismatch_d   = mismatch_q;
`endif

    if (write) begin
      case (address)
        3'd0: irq_en_d = writedata[2];
        3'd1: count_d = writedata[15:0];
        3'd2: divider_d = writedata[15:0];
`ifdef RESP_COMPARE_EN
        3'd3: expect_d = writedata[DATA_W-1:0];
        3'd4: mask_d = writedata[DATA_W-1:0];
`endif
        3'd5: begin
          if (writedata[1]) done_d = 1'b0;
          if (writedata[4]) overflow_d = 1'b0;
        end
        default: ;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (wr_start) begin
          remaining_d = count_q;
          interval_d  = divider_q;
          reload_d    = divider_q;
          done_d      = 1'b0;
          overflow_d  = 1'b0;
`ifdef RESP_COMPARE_EN
          expect_act_d = expect_q;
          mask_act_d   = mask_q;
          mismatch_d   = '0;
`endif
          state_d = (count_q == 16'd0) ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (wr_abort) begin
          state_d = S_IDLE;
        end else begin
          // a divider of 0 still spends one clock here
          interval_d = interval_q - 16'd1;
          if (interval_q <= 16'd1) state_d = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        if (wr_abort) begin
          state_d = S_IDLE;
        end else begin
          push_req    = 1'b1;
          remaining_d = remaining_q - 16'd1;
`ifdef RESP_COMPARE_EN
          if ((|((sync2_q ^ expect_act_q) & mask_act_q)) && (mismatch_q != 16'hFFFF))
            mismatch_d = mismatch_q + 16'd1;
`endif
          if (remaining_q == 16'd1) begin
            state_d = S_DONE;
          end else begin
            interval_d = reload_q;
            state_d    = S_WAIT;
          end
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // a pop frees the slot that a same-cycle push into a full FIFO uses
    pop_en  = read && (address == 3'd6) && !fifo_empty;
    push_en = push_req && (!fifo_full || pop_en);
    if (push_req && !push_en) overflow_d = 1'b1;
    if (pop_en) rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if ((state_q == S_IDLE) && wr_start) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end

    if (read) begin
      case (address)
        3'd0: readdata_d = {29'd0, irq_en_q, 1'b0, busy};
        3'd1: readdata_d = {16'd0, count_q};
        3'd2: readdata_d = {16'd0, divider_q};
`ifdef RESP_COMPARE_EN
        3'd3: readdata_d = 32'(expect_q);
        3'd4: readdata_d = 32'(mask_q);
        3'd7: readdata_d = {16'd0, mismatch_q};
`else
        3'd3, 3'd4, 3'd7: readdata_d = 32'd0;
`endif
        3'd5: readdata_d = {16'd0, 8'(level), 3'd0, overflow_q, fifo_full, fifo_empty, done_q, busy};
        3'd6: readdata_d = pop_en ? 32'(fifo_head) : 32'd0;
        default: readdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      sync1_q     <= '0;
      sync2_q     <= '0;
      count_q     <= '0;
      divider_q   <= '0;
      reload_q    <= '0;
      remaining_q <= '0;
      interval_q  <= '0;
      irq_en_q    <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      readdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= in_port;
      sync2_q     <= sync1_q;
      count_q     <= count_d;
      divider_q   <= divider_d;
      reload_q    <= reload_d;
      remaining_q <= remaining_d;
      interval_q  <= interval_d;
      irq_en_q    <= irq_en_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      readdata_q  <= readdata_d;
    end
  end

`ifdef RESP_COMPARE_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      expect_q     <= '0;
      mask_q       <= '0;
      expect_act_q <= '0;
      mask_act_q   <= '0;
      mismatch_q   <= '0;
    end else begin
      expect_q     <= expect_d;
      mask_q       <= mask_d;
      expect_act_q <= expect_act_d;
      mask_act_q   <= mask_act_d;
      mismatch_q   <= mismatch_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (push_en) fifo_mem[wr_ptr_q[AW-1:0]] <= sync2_q;
  end
endmodule

// File: tb/tb_response_capture_ctrl.sv
// Randomized bench for response_capture_ctrl: an edge-indexed history of in_port plus
// a queue model predicts sample timing, FIFO contents, STATUS and irq.
module tb_response_capture_ctrl;
  localparam int DATA_W = 11;
  localparam int DEPTH  = 16;
  localparam int HIST   = 32768;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [2:0]        address;
  logic              read, write;
  logic [31:0]       writedata, readdata;
  logic [DATA_W-1:0] in_port;
  logic              irq;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [DATA_W-1:0] in_hist [HIST];

  response_capture_ctrl #(.DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .in_port(in_port), .irq(irq)
  );

  always #5 clk = ~clk;

  // in_hist[n-1] holds the in_port value seen by rising edge number n
  always @(posedge clk) begin
    if (cyc < HIST) in_hist[cyc] <= in_port;
    cyc <= cyc + 1;
  end

  initial begin
    in_port = '0;
    forever begin
      @(negedge clk);
      in_port = DATA_W'($urandom);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    d = readdata;
  endtask

  function automatic logic [31:0] status_word(input int lvl, input bit ovf, input bit done);
    logic [31:0] st;
    st = 32'(lvl) << 8;
    if (ovf) st[4] = 1'b1;
    if (lvl == DEPTH) st[3] = 1'b1;
    if (lvl == 0) st[2] = 1'b1;
    if (done) st[1] = 1'b1;
    return st;
  endfunction

  // One capture: sample k lands at edge s + k*(w+1), w = max(divider,1), using the
  // in_port value two edges earlier; done rises one edge after the last sample.
  task automatic run_capture(input int count, input int div, input int rd_delay,
                             input int n_reads, input bit junk);
    int w, s, exp_done, pi, n_mis;
    bit ovf;
    logic [31:0] d;
    logic [DATA_W-1:0] v, ev, em;
    logic [DATA_W-1:0] q[$];
    int pop_edge[$];
    logic [31:0] pop_val[$];
    w = (div == 0) ? 1 : div;
    ev = DATA_W'($urandom);
    em = DATA_W'($urandom);
    bus_write(3'd1, 32'(count));
    bus_write(3'd2, 32'(div));
`ifdef RESP_COMPARE_EN
    bus_write(3'd3, 32'(ev));
    bus_write(3'd4, 32'(em));
`endif
    bus_write(3'd0, 32'h5);
    s = cyc;
    exp_done = s + count * (w + 1) + 1;
    $display("capture count=%0d div=%0d start_edge=%0d", count, div, s);
    if (junk && cyc + 4 <= exp_done) begin
      bus_write(3'd1, 32'($urandom_range(1, 300)));
      bus_write(3'd2, 32'($urandom_range(0, 9)));
    end
    repeat (rd_delay) if (cyc + 1 <= exp_done) @(negedge clk);
    for (int i = 0; i < n_reads && cyc + 2 <= exp_done; i++) begin
      bus_read(3'd6, d);
      pop_edge.push_back(cyc);
      pop_val.push_back(d);
    end
    for (int b = 0; b < 3000 && !irq; b++) @(negedge clk);
    check("done_edge", 32'(cyc), 32'(exp_done));

    ovf = 1'b0; n_mis = 0; pi = 0;
    for (int e = s; e <= exp_done; e++) begin
      if (pi < pop_edge.size() && pop_edge[pi] == e) begin
        d = (q.size() > 0) ? 32'(q.pop_front()) : 32'd0;
        check("pop_live", pop_val[pi], d);
        pi++;
      end
      if (e > s && (e - s) % (w + 1) == 0 && (e - s) / (w + 1) <= count) begin
        v = in_hist[e - 3];
        if (((v ^ ev) & em) != '0) n_mis++;
        if (q.size() < DEPTH) q.push_back(v);
        else ovf = 1'b1;
      end
    end

    bus_read(3'd5, d);
    check("status", d, status_word(q.size(), ovf, 1'b1));
    check("irq_set", 32'(irq), 32'd1);
    while (q.size() > 0) begin
      bus_read(3'd6, d);
      check("fifo_data", d, 32'(q.pop_front()));
    end
    bus_read(3'd6, d);
    check("fifo_empty_rd", d, 32'd0);
`ifdef RESP_COMPARE_EN
    bus_read(3'd7, d);
    check("mismatch", d, 32'(n_mis > 16'hFFFF ? 16'hFFFF : n_mis));
`else
    bus_read(3'd7, d);
    check("addr7_zero", d, 32'd0);
`endif
    bus_write(3'd5, 32'h12);
    check("irq_clr", 32'(irq), 32'd0);
    bus_read(3'd5, d);
    check("status_clr", d, status_word(0, 1'b0, 1'b0));
  endtask

  initial begin
    logic [31:0] d;
    int s, a, n;
    reset_n = 1'b0; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
    repeat (3) @(negedge clk);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_readdata", readdata, 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus_read(3'(i), d);
      check($sformatf("rst_reg%0d", i), d, (i == 5) ? 32'h4 : 32'h0);
    end

    run_capture(4, 2, 0, 0, 1'b0);
    run_capture(20, 0, 0, 0, 1'b0);
    run_capture(0, 0, 0, 0, 1'b0);
    run_capture(30, 0, 40, 12, 1'b1);
    run_capture(10, 1, 0, 10, 1'b0);
    for (int r = 0; r < 8; r++)
      run_capture($urandom_range(0, 24), $urandom_range(0, 4), $urandom_range(0, 20),
                  $urandom_range(0, 12), 1'b1);

    // abort mid-capture; a repeated start while busy must be ignored
    bus_write(3'd1, 32'd100);
    bus_write(3'd2, 32'd1);
    bus_write(3'd0, 32'h5);
    s = cyc;
    repeat (3) @(negedge clk);
    bus_write(3'd0, 32'h5);
    bus_read(3'd0, d);
    check("ctrl_busy", d, 32'h5);
    repeat (4) @(negedge clk);
    bus_write(3'd0, 32'h6);
    a = cyc;
    n = (a - s - 1) / 2;
    check("abort_irq", 32'(irq), 32'd0);
    bus_read(3'd5, d);
    check("abort_status", d, status_word(n, 1'b0, 1'b0));
    for (int k = 1; k <= n; k++) begin
      bus_read(3'd6, d);
      check("abort_data", d, 32'(in_hist[s + 2 * k - 3]));
    end
    repeat (5) @(negedge clk);
    check("abort_irq_late", 32'(irq), 32'd0);

    // start and abort together: abort wins
    bus_write(3'd1, 32'd5);
    bus_write(3'd0, 32'h7);
    bus_read(3'd5, d);
    check("start_abort", d, status_word(0, 1'b0, 1'b0));

    // reset mid-capture
    bus_write(3'd1, 32'd50);
    bus_write(3'd2, 32'd0);
    bus_write(3'd0, 32'h5);
    repeat (15) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_irq", 32'(irq), 32'd0);
    check("midrst_rdata", readdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    bus_read(3'd5, d);
    check("midrst_status", d, status_word(0, 1'b0, 1'b0));
    bus_read(3'd0, d);
    check("midrst_ctrl", d, 32'd0);
    repeat (60) @(negedge clk);
    check("midrst_no_irq", 32'(irq), 32'd0);
    run_capture(6, 3, 2, 3, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
